spart_tx: RTL and testbench
===========================

// Module: spart_tx
// PURPOSE
//   SPART transmit stage. Consumes the 16x-oversample baud tick (Enable, one clk
//   pulse every 163 clk) from the baud generator and serialises bytes onto txd.
//   Frame format: 8N1, LSB first. A one-byte holding register in front of the
//   shift register lets the host queue the next byte during a frame, so
//   back-to-back frames have no idle gap.
// PARAMETERS
//   DATA_BITS   8    data bits per frame
//   OVERSAMPLE  16   baud_en ticks per bit period
// PORTS
//   clk       in   1          system clock; all logic on posedge
//   rst       in   1          asynchronous, active-high reset
//   baud_en   in   1          1-clk tick at OVERSAMPLE x baud (baud generator Enable)
//   tx_wr     in   1          write strobe; accepted only when tx_ready=1
//   tx_data   in   DATA_BITS  byte to send; sampled on an accepted tx_wr
//   tx_ready  out  1          holding register empty
//   tx_busy   out  1          frame in progress (state != IDLE)
//   txd       out  1          serial line; idles high
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, txd=1, hold_valid=0, tick_cnt=0, bit_cnt=0.
//     Outputs during and after reset: tx_ready=1, tx_busy=0.
//     Reset mid-frame abandons the frame. txd returns to 1 with no clock edge.
//   Holding register:
//     - On posedge with tx_wr=1 and tx_ready=1: hold<=tx_data, hold_valid<=1.
//     - tx_wr with tx_ready=0 is ignored: no state change, no error flag.
//     - tx_ready = !hold_valid (registered state, no combinational path from tx_wr).
//   States: IDLE, START, DATA, STOP. tick_cnt counts baud_en pulses (0..OVERSAMPLE-1).
//     - IDLE: txd=1. On baud_en=1 with hold_valid=1:
//         shift<=hold, hold_valid<=0, tick_cnt<=0, go to START.
//         txd=0 from the following clock.
//       If tx_wr arrives in the same cycle as this load, it is ignored,
//       because tx_ready was 0 in that cycle.
//     - Bit advance: on baud_en=1 with tick_cnt==OVERSAMPLE-1, set tick_cnt<=0
//       and move to the next bit. Otherwise baud_en=1 increments tick_cnt.
//       Each bit therefore lasts exactly OVERSAMPLE baud_en ticks.
//     - START -> DATA: txd=shift[0], bit_cnt<=0.
//     - DATA: on each advance, shift>>=1, txd=next bit, bit_cnt++.
//       After bit DATA_BITS-1 completes: txd=1, go to STOP.
//     - STOP, at the end of the stop bit:
//         hold_valid=1 -> reload as in IDLE and go straight to START (no idle bit);
//         otherwise -> IDLE.
//   baud_en=0 freezes every counter and txd; the frame simply stretches.
//   txd is driven directly from a flop (glitch-free). Latency from an accepted
//   tx_wr while idle: start bit begins 1 clk after the next baud_en pulse.
//   tx_busy = (state != IDLE); it stays 1 across back-to-back frames.
// TESTING (bench drives baud_en every 4 clk for speed; 1 bit = 64 clk)
//   1. Assert rst, no clk edges -> txd=1, tx_ready=1, tx_busy=0 immediately.
//   2. Write 0xA5 while idle -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
//      tx_ready=1 again 1 clk after the start-bit load.
//   3. Write 0x55, then 0x0F during its frame -> 20 contiguous bit times.
//      The stop bit of 0x55 is followed directly by the 0x0F start bit.
//      tx_busy stays 1 throughout.
//   4. Write 0x55, write 0x0F, then write 0xFF while tx_ready=0 ->
//      only the 0x55 and 0x0F frames appear; 0xFF is never sent.
//   5. Pulse rst during data bit 4 of 0xC3 -> txd=1 and tx_ready=1 at once.
//      A following write of 0x3C sends a complete, correct frame.
//   6. Hold baud_en=0 for 500 clk mid-start-bit -> txd stays 0.
//      Frame resumes and finishes with correct per-bit tick counts.

Source files
------------

// File: rtl/spart_tx.sv
// SPART transmit stage: one-byte holding register in front of an 8N1
// shift register, paced by the 16x oversample baud tick (baud_en).
//
// Handshake: tx_ready is registered (= holding register empty); a write is
// taken on any posedge where tx_wr=1 and tx_ready=1, and silently dropped
// otherwise. tx_ready has no combinational path from tx_wr.
module spart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd,
  output logic [1:0]           dbg_state
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;

  logic tick_last;
  logic bit_last;
  logic load;

  // End of the current bit period, and a holding-register -> shifter transfer
  // (from IDLE on any tick, or straight out of STOP for back-to-back frames).
  always_comb begin
    tick_last = baud_en && (tick_cnt_q == TICK_LAST);
    bit_last  = (bit_cnt_q == BIT_LAST);
    load      = hold_valid_q &&
                (((state_q == IDLE) && baud_en) || ((state_q == STOP) && tick_last));
  end

  // State register plus datapath flops; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      txd_q        <= txd_d;
    end
  end

  // Next-state logic: every bit boundary is a full OVERSAMPLE-tick period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (load) state_d = START;
      START: if (tick_last) state_d = DATA;
      DATA:  if (tick_last && bit_last) state_d = STOP;
      STOP:  if (tick_last) state_d = hold_valid_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: holding register, tick/bit counters, shifter, txd.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    txd_d        = txd_q;

    // Host write into the holding register; load never coincides with an
    // accepted write because load needs hold_valid_q=1 (tx_ready=0).
    if (tx_wr && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    if ((state_q != IDLE) && baud_en) begin
      tick_cnt_d = tick_last ? '0 : tick_cnt_q + TW'(1);
    end

    case (state_q)
      START: begin
        if (tick_last) begin
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick_last) begin
          if (bit_last) begin
            txd_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick_last) txd_d = 1'b1;
      end
      default: txd_d = 1'b1;
    endcase

    // Start bit begins on the clock after the loading tick.
    if (load) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      tick_cnt_d   = '0;
      txd_d        = 1'b0;
    end
  end

  // Outputs are straight from flops; txd is glitch-free.
  always_comb begin
    tx_ready  = !hold_valid_q;
    tx_busy   = (state_q != IDLE);
    txd       = txd_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: baud_en every 4 clk, so one bit = 64 clk.
// txd is compared clock by clock against hand-written LSB-first bit vectors.
module tb_spart_tx;

  logic       clk;
  logic       rst;
  logic       baud_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       txd;
  logic [1:0] dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int bcnt     = 0;
  logic gate   = 1'b1;

  localparam int BIT_CLK = 64;
  localparam int FREEZE  = 500;

  spart_tx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_en   (baud_en),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .txd       (txd),
    .dbg_state (dbg_state)
  );

  // Clock and baud tick (one pulse every 4 clk, gated for the freeze test)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt    = (bcnt + 1) % 4;
      baud_en = gate && (bcnt == 3);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ready);
    chk({tag, "_ready"}, 32'(tx_ready), 32'(exp_ready));
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  // Returns at the negedge where txd first reads 0 (clock 0 of the start bit).
  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (txd === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  // Checks n_bits of line waveform, optional mid-frame writes and a baud
  // freeze, then idle_clks of idle line with tx_busy low.
  task automatic check_frame(input string tag, input logic [19:0] exp_bits, input int n_bits,
                             input int idle_clks,
                             input int w1_at, input logic [7:0] w1_data,
                             input int w2_at, input logic [7:0] w2_data,
                             input int frz_at);
    logic [19:0] bad;
    logic [19:0] obs_v;
    logic        busy_obs, busy_bad, idle_obs, idle_bad, idle_busy;
    int          total, ei, b;
    bad = '0; obs_v = '0;
    busy_obs = 1'b1; busy_bad = 1'b0;
    idle_obs = 1'b1; idle_bad = 1'b0; idle_busy = 1'b0;
    wait_start(tag);
    chk({tag, "_ready_at_start"}, 32'(tx_ready), 32'd1);
    total = n_bits * BIT_CLK + ((frz_at >= 0) ? FREEZE : 0);
    for (int i = 0; i < total; i++) begin
      if (frz_at >= 0 && i >= frz_at) ei = (i >= frz_at + FREEZE) ? i - FREEZE : frz_at;
      else ei = i;
      b = ei / BIT_CLK;
      if (txd !== exp_bits[b]) begin
        bad[b]   = 1'b1;
        obs_v[b] = txd;
      end else if (!bad[b]) begin
        obs_v[b] = txd;
      end
      if (tx_busy !== 1'b1) begin
        busy_bad = 1'b1;
        busy_obs = tx_busy;
      end
      tx_wr = 1'b0;
      if (i == w1_at) begin
        chk({tag, "_w1_ready"}, 32'(tx_ready), 32'd1);
        tx_data = w1_data;
        tx_wr   = 1'b1;
      end
      if (i == w2_at) begin
        chk({tag, "_w2_ready"}, 32'(tx_ready), 32'd0);
        tx_data = w2_data;
        tx_wr   = 1'b1;
      end
      if (frz_at >= 0 && i == frz_at) gate = 1'b0;
      if (frz_at >= 0 && i == frz_at + FREEZE) gate = 1'b1;
      @(negedge clk);
    end
    tx_wr = 1'b0;
    for (int j = 0; j < n_bits; j++)
      chk($sformatf("%s_bit%0d", tag, j), 32'(obs_v[j]), 32'(exp_bits[j]));
    chk({tag, "_busy_in_frame"}, 32'(busy_obs), 32'd1);
    for (int i = 0; i < idle_clks; i++) begin
      if (txd !== 1'b1 && !idle_bad) begin
        idle_bad = 1'b1;
        idle_obs = txd;
      end
      if (tx_busy !== 1'b0) idle_busy = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_idle_txd"}, 32'(idle_obs), 32'd1);
    chk({tag, "_idle_busy"}, 32'(idle_busy), 32'd0);
    chk({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Directed sequence
  initial begin
    logic post_obs;
    rst = 1'b0; tx_wr = 1'b0; tx_data = 8'h00;

    // 1: reset with no clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: single frame 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    write_byte("t2_wr", 8'hA5, 1'b1);
    chk("t2_ready_after_wr", 32'(tx_ready), 32'd0);
    check_frame("t2", 20'h0034A, 10, 100, -1, 8'h00, -1, 8'h00, -1);

    // 3: 0x55 then 0x0F queued mid-frame -> 20 contiguous bits
    write_byte("t3_wr", 8'h55, 1'b1);
    check_frame("t3", {10'h21E, 10'h2AA}, 20, 100, 100, 8'h0F, -1, 8'h00, -1);

    // 4: as 3, plus 0xFF written while the holding register is full
    write_byte("t4_wr", 8'h55, 1'b1);
    check_frame("t4", {10'h21E, 10'h2AA}, 20, 300, 100, 8'h0F, 200, 8'hFF, -1);

    // 5: reset during data bit 4 of 0xC3 with 0x99 queued
    write_byte("t5_wr", 8'hC3, 1'b1);
    wait_start("t5");
    repeat (100) @(negedge clk);
    write_byte("t5_wr_queued", 8'h99, 1'b1);
    repeat (5 * BIT_CLK + 30 - 101) @(negedge clk);
    chk("t5_pre_rst_txd", 32'(txd), 32'd0);
    chk("t5_pre_rst_ready", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_txd", 32'(txd), 32'd1);
    chk("t5_rst_ready", 32'(tx_ready), 32'd1);
    chk("t5_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    post_obs = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1) post_obs = txd;
      @(negedge clk);
    end
    chk("t5_abandoned_idle", 32'(post_obs), 32'd1);
    write_byte("t5_wr2", 8'h3C, 1'b1);
    check_frame("t5_3c", 20'h00278, 10, 100, -1, 8'h00, -1, 8'h00, -1);

    // 6: baud_en held low for 500 clk inside the start bit of 0x96
    write_byte("t6_wr", 8'h96, 1'b1);
    check_frame("t6", 20'h0032C, 10, 100, -1, 8'h00, -1, 8'h00, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
